// File: rtl/ldpc_pkg.sv
// Shared constants and FSM encoding for the LDPC encoder frame sequencer.
// The accumulator geometry is fixed per code rate; K_BITS must be a multiple of M_BITS.
package ldpc_pkg;

  localparam int K_BITS     = 4320;
  localparam int M_BITS     = 360;
  localparam int CNT_W      = 13;
  localparam int ADDR_W     = 9;
  localparam int CLR_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_INFO   = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_PARITY = 3'd4,
    ST_DRAIN  = 3'd5
  } ctrl_state_e;

endpackage

// File: rtl/ldpc_out_align.sv
// Codeword output stage: merges forwarded systematic bits with accumulator read-back,
// delaying the parity strobe one cycle to line up with the registered accumulator dout.
module ldpc_out_align (
  input  logic clk,
  input  logic rst_n,
  input  logic sys_valid,
  input  logic sys_data,
  input  logic sys_first,
  input  logic par_rd,
  input  logic par_last,
  input  logic enc_parity,
  output logic m_valid,
  output logic m_data,
  output logic m_sop,
  output logic m_eop
);

  logic rd_v;
  logic rd_last;

  // rd_v marks the cycle in which enc_parity holds the bit addressed one cycle earlier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v    <= 1'b0;
      rd_last <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= 1'b0;
      m_sop   <= 1'b0;
      m_eop   <= 1'b0;
    end else begin
      rd_v    <= par_rd;
      rd_last <= par_last;
      m_valid <= sys_valid | rd_v;
      m_data  <= sys_valid ? sys_data : (rd_v & enc_parity);
      m_sop   <= sys_valid & sys_first;
      m_eop   <= rd_v & rd_last;
    end
  end

endmodule

// File: rtl/ldpc_enc_ctrl.sv
// Frame sequencer for the 360-column parity accumulator: clears it, streams info bits
// into it, reads parity back MSB-address first and emits one serial codeword per frame.
module ldpc_enc_ctrl
  import ldpc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic              s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              enc_clr_n,
  output logic              enc_din_valid,
  output logic              enc_din,
  output logic [CNT_W-1:0]  enc_counter,
  output logic [ADDR_W-1:0] enc_out_addr,
  output logic              enc_data_valid_check,
  input  logic              enc_parity,
  output logic              m_valid,
  output logic              m_data,
  output logic              m_sop,
  output logic              m_eop,
  output logic              busy,
  output logic              frame_done,
  output logic              err_len
);

  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(K_BITS - 1);
  localparam logic [ADDR_W-1:0] ADDR_TOP  = ADDR_W'(M_BITS - 1);
  localparam logic [1:0]        CLR_LAST  = 2'(CLR_CYCLES - 1);

  ctrl_state_e       state;
  logic [1:0]        clr_cnt;
  logic              drain_cnt;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr;
  logic              clr_n_q;
  logic              dvc_q;
  logic              err_q;
  logic              done_q;

  logic accept;
  logic at_last_idx;
  logic len_err;
  logic sys_valid;

  // Input handshake: a bit transfers on a cycle where s_valid & s_ready are both high;
  // s_ready depends only on state, never on s_valid, and the source holds its bit until taken.
  always_comb begin
    s_ready     = (state == ST_INFO);
    accept      = s_valid & s_ready;
    at_last_idx = (cnt == LAST_IDX);
    len_err     = accept & (s_last ^ at_last_idx);
    sys_valid   = accept & ~len_err;
  end

  assign enc_din_valid        = accept;
  assign enc_din              = accept & s_data;
  assign enc_counter          = cnt;
  assign enc_out_addr         = addr;
  assign enc_data_valid_check = dvc_q;
  assign enc_clr_n            = clr_n_q;
  assign busy                 = (state != ST_IDLE);
  assign frame_done           = done_q;
  assign err_len              = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      clr_cnt   <= 2'd0;
      drain_cnt <= 1'b0;
      cnt       <= '0;
      addr      <= ADDR_TOP;
      clr_n_q   <= 1'b1;
      dvc_q     <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      err_q  <= 1'b0;
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (s_valid) begin
            state   <= ST_CLEAR;
            clr_n_q <= 1'b0;
            clr_cnt <= 2'd0;
            cnt     <= '0;
          end
        end
        ST_CLEAR: begin
          cnt <= '0;
          if (clr_cnt == CLR_LAST) begin
            state   <= ST_INFO;
            clr_n_q <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 2'd1;
          end
        end
        ST_INFO: begin
          if (accept) begin
            if (len_err) begin
              err_q <= 1'b1;
              state <= ST_IDLE;
            end else if (at_last_idx) begin
              state <= ST_FLUSH;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          // Gives the accumulator one cycle to absorb the final info bit before read-back.
          state <= ST_PARITY;
          dvc_q <= 1'b1;
          addr  <= ADDR_TOP;
        end
        ST_PARITY: begin
          if (addr == '0) begin
            state     <= ST_DRAIN;
            dvc_q     <= 1'b0;
            addr      <= ADDR_TOP;
            drain_cnt <= 1'b0;
          end else begin
            addr <= addr - 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ldpc_out_align u_out_align (
    .clk        (clk),
    .rst_n      (rst_n),
    .sys_valid  (sys_valid),
    .sys_data   (s_data),
    .sys_first  (cnt == '0),
    .par_rd     (dvc_q),
    .par_last   (dvc_q & (addr == '0)),
    .enc_parity (enc_parity),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_sop      (m_sop),
    .m_eop      (m_eop)
  );

endmodule

// File: doc/ldpc_enc_ctrl.md
Name: ldpc_enc_ctrl

Overview:
- Frame sequencer for the 360-column parity accumulator (encoder4-class block) of the LDPC encoder.
- Accepts a serial information-bit stream over a valid/ready handshake.
- Drives the accumulator's din_valid, din, counter, out_addr and data_valid_check inputs and its clear input.
- Merges the systematic bits and the read-back parity bits into one serial codeword stream with start/end markers.

Parameters:
- K_BITS, 4320, information bits per frame; must be a multiple of M_BITS.
- M_BITS, 360, parity bits per frame (accumulator width).
- CNT_W, 13, width of the info-bit counter.
- ADDR_W, 9, width of the parity read address.
- CLR_CYCLES, 2, cycles the accumulator clear is held low (covers ROM read latency).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  info bit valid
- s_data  in  1  info bit
- s_last  in  1  marks last info bit of frame
- s_ready  out  1  controller accepts s_data
- enc_clr_n  out  1  accumulator clear (active low, synchronous at accumulator)
- enc_din_valid  out  1  accumulator bit strobe
- enc_din  out  1  accumulator bit
- enc_counter  out  CNT_W  index of current info bit
- enc_out_addr  out  ADDR_W  parity bit select
- enc_data_valid_check  out  1  parity read enable
- enc_parity  in  1  accumulator dout, registered, valid 1 cycle after enc_out_addr
- m_valid  out  1  codeword bit valid (no backpressure)
- m_data  out  1  codeword bit
- m_sop  out  1  first codeword bit
- m_eop  out  1  last codeword bit
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after m_eop
- err_len  out  1  one-cycle pulse on length error

Behaviour:
- Reset (async, rst_n low), all outputs at reset:
  - state=IDLE; enc_clr_n=1; enc_counter=0; enc_out_addr=M_BITS-1.
  - All other outputs 0.
  - A reset mid-frame abandons the frame with no m_eop and no frame_done.
- FSM states: IDLE, CLEAR, INFO, FLUSH, PARITY, DRAIN.
- IDLE:
  - s_ready=0.
  - s_valid=1 moves to CLEAR; that bit is held upstream, not consumed.
- CLEAR:
  - enc_clr_n=0 and enc_counter=0 for CLR_CYCLES cycles, then INFO.
  - busy=1 from CLEAR through DRAIN.
- INFO:
  - s_ready=1.
  - On accept (s_valid & s_ready), the same cycle combinationally gives enc_din_valid=1, enc_din=s_data, enc_counter=count of bits already accepted (0..K_BITS-1).
  - enc_counter increments after each accept and holds during s_valid gaps.
- INFO systematic output:
  - The accepted bit is registered to m_data with m_valid=1 on the next cycle.
  - m_sop=1 with bit 0.
- INFO exit:
  - Accept with enc_counter=K_BITS-1 and s_last=1 goes to FLUSH.
  - Length error: s_last=1 on any other index, or s_last=0 at index K_BITS-1.
  - On a length error: err_len pulses, the bit is accepted but not forwarded, m_valid is suppressed, and the state goes to IDLE with no m_eop.
  - The next frame re-clears the accumulator.
- FLUSH:
  - One cycle, s_ready=0, enc_din_valid=0, so the final XOR settles in the accumulator.
  - Then PARITY.
- PARITY:
  - M_BITS cycles with enc_data_valid_check=1.
  - enc_out_addr counts M_BITS-1 down to 0, one per cycle.
  - After addr 0 goes to DRAIN; enc_out_addr returns to M_BITS-1.
- Parity output alignment:
  - enc_parity is captured one cycle after each address.
  - It is presented on m_data/m_valid one further cycle later, so latency is address to m_data = 2 cycles.
  - The last parity bit carries m_eop=1.
- DRAIN:
  - Two cycles, to flush the alignment pipeline.
  - frame_done pulses in the cycle after m_eop; then IDLE.
- Output timing:
  - Codeword = K_BITS systematic bits, then M_BITS parity bits.
  - The parity m_valid run is contiguous.
  - Systematic m_valid gaps mirror s_valid gaps.
- Counter arithmetic:
  - Unsigned, no wrap inside a frame.
  - enc_counter is reset to 0 in CLEAR.
- enc_data_valid_check is 0 outside PARITY, which forces accumulator dout to 0.
- s_valid asserted during FLUSH, PARITY or DRAIN is ignored (s_ready=0).

Decomposition:
- Package ldpc_pkg holds:
  - Localparams K_BITS, M_BITS, CNT_W, ADDR_W.
  - State encoding constants.
- Natural sub-module: ldpc_out_align. It holds the 2-stage parity alignment pipe and the systematic/parity output mux with m_sop/m_eop generation.
- The FSM and counters stay in the top module.

Test Plan:
- Back-to-back frame, all-ones s_data, s_valid held high:
  - CLEAR lasts 2 cycles.
  - enc_din_valid runs 4320 cycles with enc_counter 0..4319.
  - m_valid runs 4320+360 cycles with m_sop on bit 0 and m_eop on bit 4679.
  - frame_done fires 1 cycle after m_eop.
- Parity ordering, bench models enc_parity = enc_out_addr[0] delayed 1 cycle:
  - The parity m_data sequence starts 1,0,1,0,... (addr 359 first).
  - Parity bit 0 appears 2 cycles after enc_out_addr=359.
- Random s_valid gaps (~30% idle):
  - enc_counter and the systematic m_valid pattern track accepts exactly.
  - enc_counter holds during gaps.
  - The parity phase remains contiguous.
- Early s_last at index 1000:
  - err_len pulses once and the FSM returns to IDLE.
  - No m_eop and no frame_done.
  - The next frame starts with a CLEAR and completes normally.
- Missing s_last at index 4319: err_len pulses, no parity phase is entered, and enc_data_valid_check stays 0.
- rst_n asserted during PARITY at addr 200:
  - Outputs immediately take reset values, with enc_out_addr=359.
  - The following frame is correct.
